adat_frame_writer: RTL and testbench
====================================

ADAT_FRAME_WRITER -- requirements
Module: adat_frame_writer

Interface
REQ-001 Parameter CIRC_BUF_BITS, default 3, log2 of frame slots in channel_buffer.
REQ-002 Parameter LOCK_COUNT, default 2, consecutive good/bad frames to gain/lose lock.
REQ-003 clk_i  in  1  single clock, shared with channel_buffer write port.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 bit_i  in  1  NRZI-decoded ADAT bit, qualified by bit_valid_i.
REQ-006 bit_valid_i  in  1  one-cycle strobe per received bit; never on consecutive cycles.
REQ-007 write_data_o  out  1  bit to channel_buffer.
REQ-008 write_addr_o  out  CIRC_BUF_BITS+8  address {slot, channel[2:0], bit_pos[4:0]}.
REQ-009 wr_en_o  out  1  channel_buffer write enable.
REQ-010 last_good_frame_idx_o  out  CIRC_BUF_BITS  slot of newest committed frame.
REQ-011 user_bits_o  out  4  user nibble of newest committed frame.
REQ-012 resync_req_o  out  1  high while unlocked; consumed by i2s_msb_transmitter.

Function
REQ-013 Frame format: 10-zero sync, start '1', 4 user bits, 48 groups of separator '1' + 4 data bits, 1 trailing '0'; period 256 bits start-to-start.
REQ-014 FSM states: HUNT, USER, SEP, DATA, TAIL; one transition per bit_valid_i only.
REQ-015 HUNT: count zeros (saturating at 15); '1' after >=10 zeros -> USER, else restart count.
REQ-016 USER: capture 4 bits MSB-first -> SEP.
REQ-017 SEP: '1' -> DATA; '0' -> frame bad, HUNT with zero count 1.
REQ-018 DATA: 4 bits, then SEP, or TAIL after nibble 48.
REQ-019 TAIL: count zeros; '1' with exactly 11 zeros -> good frame, commit, USER; '1' with other count -> bad, USER if count>=10 else HUNT; count reaching 16 -> bad, HUNT.
REQ-020 Each data bit written next cycle: wr_en_o=1 for one cycle, channel=nibble/6, bit_pos=23-(bits seen in channel), MSB first.
REQ-021 bit_pos 24..31 never written.
REQ-022 Slot = internal write_idx; all writes of a frame use the same slot.
REQ-023 Commit: last_good_frame_idx_o<=write_idx, user_bits_o<=captured nibble, write_idx<=write_idx+1 modulo 2^CIRC_BUF_BITS (7->0 wraps).
REQ-024 Bad frame: write_idx unchanged; slot overwritten by next frame; outputs unchanged.
REQ-025 Lock: LOCK_COUNT consecutive good frames clear resync_req_o in commit cycle; LOCK_COUNT consecutive bad frames set it; a good frame clears bad count and vice versa.
REQ-026 Commit and first write of next frame never coincide (bit spacing); no arbitration needed.
REQ-027 Outputs all registered; write latency one clk_i after bit_valid_i.

Reset
REQ-028 On rst_ni low, immediately: state HUNT, counters 0, write_idx 0, wr_en_o 0, write_data_o 0, write_addr_o 0, last_good_frame_idx_o 0, user_bits_o 0, resync_req_o 1.
REQ-029 Reset mid-frame discards partial frame; after release, first frame requires full sync.

Structure
REQ-030 Shared package adat_pkg: frame constants (SYNC_ZEROS=10, TAIL_ZEROS=11, NIBBLES=48, CHANNELS=8, SAMPLE_BITS=24) and FSM state enum.
REQ-031 One sub-module adat_sync_detector (zero-run counter, sync flag); rest in top.

Verification
REQ-032 Reset, then 3 good frames with user=4'hA, ch0=24'h800001 -> resync_req_o falls at 2nd commit; last_good_frame_idx_o 0,1,2; ram[{3'd0,3'd0,5'd0}]=1, bit_pos 23 of slot 0 ch0 =1.
REQ-033 Good frame, frame with separator 21 forced 0, good frame -> 2nd good frame stored in slot 1, last_good_frame_idx_o 0 then 1, resync_req_o unchanged.
REQ-034 10 good frames -> last_good_frame_idx_o sequence 0..7,0,1; write_addr_o slot field wraps 7->0.
REQ-035 Locked, then 2 frames with 12-zero tails -> resync_req_o=1 after 2nd; 2 good frames -> 0.
REQ-036 rst_ni low at data nibble 20 for 3 cycles -> all outputs at reset values asynchronously; no wr_en_o until after next sync.
REQ-037 Bit stream of 300 zeros -> no wr_en_o, HUNT held, resync_req_o stays 1.

Source files
------------

// File: rtl/adat_pkg.sv
// adat_pkg: ADAT frame geometry constants and the frame-parser state encoding.
package adat_pkg;
    localparam int SYNC_ZEROS  = 10;
    localparam int TAIL_ZEROS  = 11;
    localparam int NIBBLES     = 48;
    localparam int CHANNELS    = 8;
    localparam int SAMPLE_BITS = 24;
    typedef enum logic [2:0] {HUNT, USER, SEP, DATA, TAIL} adat_state_e;
endpackage

// File: rtl/adat_sync_detector.sv
// adat_sync_detector: zero-run counter over qualified bits (saturating at 15) with a sync-run flag.
module adat_sync_detector
    import adat_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    input  logic       restart_i,
    input  logic       clear_i,
    output logic [3:0] zero_cnt_o,
    output logic       sync_o
);
    logic [3:0] base;
    // restart counts the current bit as the first of a fresh run; clear forces an empty run
    assign base = restart_i ? 4'd0 : zero_cnt_o;
    assign sync_o = zero_cnt_o >= 4'(SYNC_ZEROS);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) zero_cnt_o <= 4'd0;
        else if (bit_valid_i) zero_cnt_o <= (bit_i || clear_i) ? 4'd0 : (&base ? base : base + 4'd1);
endmodule

// File: rtl/adat_frame_writer.sv
// adat_frame_writer: parses ADAT frames from a decoded bit stream, writes sample bits
// into a circular channel buffer and tracks frame lock.
module adat_frame_writer
    import adat_pkg::*;
#(
    parameter int CIRC_BUF_BITS = 3,
    parameter int LOCK_COUNT    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     bit_i,
    input  logic                     bit_valid_i,
    output logic                     write_data_o,
    output logic [CIRC_BUF_BITS+7:0] write_addr_o,
    output logic                     wr_en_o,
    output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
    output logic [3:0]               user_bits_o,
    output logic                     resync_req_o
);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    adat_state_e state, state_nx;
    logic [3:0] zero_cnt, user_sh;
    logic [1:0] user_cnt;
    logic [2:0] ch;
    logic [4:0] pos;
    logic [CIRC_BUF_BITS-1:0] write_idx;
    logic [LW-1:0] good_cnt, bad_cnt;
    logic sync, frame_end, good, bad, data_bit;

    adat_sync_detector u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bit_i      (bit_i),
        .bit_valid_i(bit_valid_i),
        .restart_i  (state == SEP),
        .clear_i    (state == USER || state == DATA),
        .zero_cnt_o (zero_cnt),
        .sync_o     (sync)
    );

    // pos counts down within a channel, so a nibble ends whenever pos is a multiple of 4
    assign frame_end = ch == 3'(CHANNELS - 1) && pos == 5'd0;
    assign data_bit  = bit_valid_i && state == DATA;
    assign good = bit_valid_i && state == TAIL && bit_i && zero_cnt == 4'(TAIL_ZEROS);
    assign bad  = bit_valid_i && ((state == SEP && !bit_i) ||
                  (state == TAIL && (bit_i ? zero_cnt != 4'(TAIL_ZEROS) : &zero_cnt)));

    always_comb begin
        state_nx = state;
        if (bit_valid_i)
            case (state)
                HUNT:    state_nx = (bit_i && sync) ? USER : HUNT;
                USER:    state_nx = &user_cnt ? SEP : USER;
                SEP:     state_nx = bit_i ? DATA : HUNT;
                DATA:    state_nx = pos[1:0] != 2'd0 ? DATA : (frame_end ? TAIL : SEP);
                TAIL:    state_nx = bit_i ? (sync ? USER : HUNT) : (&zero_cnt ? HUNT : TAIL);
                default: state_nx = HUNT;
            endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state                 <= HUNT;
            user_sh               <= 4'd0;
            user_cnt              <= 2'd0;
            ch                    <= 3'd0;
            pos                   <= 5'd0;
            write_idx             <= '0;
            good_cnt              <= '0;
            bad_cnt               <= '0;
            wr_en_o               <= 1'b0;
            write_data_o          <= 1'b0;
            write_addr_o          <= '0;
            last_good_frame_idx_o <= '0;
            user_bits_o           <= 4'd0;
            resync_req_o          <= 1'b1;
        end else begin
            state   <= state_nx;
            wr_en_o <= data_bit;
            if (data_bit) begin
                write_data_o <= bit_i;
                write_addr_o <= {write_idx, ch, pos};
                ch           <= pos == 5'd0 ? ch + 3'd1 : ch;
                pos          <= pos == 5'd0 ? 5'(SAMPLE_BITS - 1) : pos - 5'd1;
            end
            if (bit_valid_i && state == USER) begin
                user_sh  <= {user_sh[2:0], bit_i};
                user_cnt <= user_cnt + 2'd1;
            end
            if (state_nx == USER && state != USER) begin
                user_cnt <= 2'd0;
                ch       <= 3'd0;
                pos      <= 5'(SAMPLE_BITS - 1);
            end
            if (good) begin
                last_good_frame_idx_o <= write_idx;
                user_bits_o           <= user_sh;
                write_idx             <= write_idx + 1'b1;
                bad_cnt               <= '0;
                good_cnt              <= good_cnt == LW'(LOCK_COUNT) ? good_cnt : good_cnt + 1'b1;
                if (good_cnt >= LW'(LOCK_COUNT - 1)) resync_req_o <= 1'b0;
            end
            if (bad) begin
                good_cnt <= '0;
                bad_cnt  <= bad_cnt == LW'(LOCK_COUNT) ? bad_cnt : bad_cnt + 1'b1;
                if (bad_cnt >= LW'(LOCK_COUNT - 1)) resync_req_o <= 1'b1;
            end
        end
endmodule

// File: tb/tb_adat_frame_writer.sv
// tb_adat_frame_writer: randomized ADAT frame streams checked against a frame-level reference model.
module tb_adat_frame_writer;
    localparam int CB = 3;
    localparam int LC = 2;
    localparam int BADSEP = 21;

    logic clk_i = 1'b0, rst_ni = 1'b0, bit_i = 1'b0, bit_valid_i = 1'b0;
    logic write_data_o, wr_en_o, resync_req_o;
    logic [CB+7:0] write_addr_o;
    logic [CB-1:0] last_good_frame_idx_o;
    logic [3:0] user_bits_o;

    int checks = 0, errors = 0;
    logic [CB+8:0] exp_q[$];
    logic ram [0:(1<<(CB+8))-1];
    logic [23:0] smp [8];
    int m_widx, m_last, m_user, m_good, m_bad, pending, p_user;
    logic m_resync;

    adat_frame_writer #(.CIRC_BUF_BITS(CB), .LOCK_COUNT(LC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
        .write_data_o(write_data_o), .write_addr_o(write_addr_o), .wr_en_o(wr_en_o),
        .last_good_frame_idx_o(last_good_frame_idx_o), .user_bits_o(user_bits_o),
        .resync_req_o(resync_req_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // every buffer write is matched in order against the model's expected writes
    always @(negedge clk_i) if (wr_en_o === 1'b1) begin
        logic [CB+8:0] e;
        ram[write_addr_o] = write_data_o;
        if (exp_q.size() == 0) check("wr_unexpected", wr_en_o, 0);
        else begin
            e = exp_q.pop_front();
            check("wr_addr", write_addr_o, e[CB+8:1]);
            check("wr_data", write_data_o, e[0]);
        end
    end

    task automatic send_bit(input logic b);
        bit_i = b;
        bit_valid_i = 1'b1;
        @(negedge clk_i);
        bit_valid_i = 1'b0;
        bit_i = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_wr_en", wr_en_o, 0);
        check("rst_wr_addr", write_addr_o, 0);
        check("rst_wr_data", write_data_o, 0);
        check("rst_last_idx", last_good_frame_idx_o, 0);
        check("rst_user", user_bits_o, 0);
        check("rst_resync", resync_req_o, 1);
        m_widx = 0; m_last = 0; m_user = 0; m_good = 0; m_bad = 0; m_resync = 1'b1; pending = 0;
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // frame outcomes become visible by the start bit of the following frame
    task automatic apply_and_check();
        if (pending == 1) begin
            m_last = m_widx; m_user = p_user; m_widx = (m_widx + 1) % (1 << CB);
            m_bad = 0; m_good++;
            if (m_good >= LC) m_resync = 1'b0;
        end else if (pending == 2) begin
            m_good = 0; m_bad++;
            if (m_bad >= LC) m_resync = 1'b1;
        end
        pending = 0;
        check("last_idx", last_good_frame_idx_o, m_last);
        check("user_bits", user_bits_o, m_user);
        check("resync", resync_req_o, m_resync);
    endtask

    task automatic rand_samples();
        for (int c = 0; c < 8; c++) smp[c] = 24'($urandom);
    endtask

    // kind 0 good, 1 separator BADSEP forced low, 2 twelve-zero tail; cut stops before that nibble
    task automatic send_frame(input int kind, input logic [3:0] user, input int cut = 48);
        int n;
        n = (kind == 1) ? BADSEP : 48;
        if (cut < n) n = cut;
        repeat (10) send_bit(1'b0);
        send_bit(1'b1);
        apply_and_check();
        for (int j = 0; j < n; j++)
            for (int b = 0; b < 4; b++) begin
                int c, p;
                c = j / 6;
                p = 23 - ((j % 6) * 4 + b);
                exp_q.push_back({m_widx[CB-1:0], c[2:0], p[4:0], smp[c][p]});
            end
        for (int k = 3; k >= 0; k--) send_bit(user[k]);
        for (int j = 0; j < 48; j++) begin
            if (j == cut) return;
            send_bit(!(kind == 1 && j == BADSEP));
            for (int b = 0; b < 4; b++) send_bit(smp[j / 6][23 - ((j % 6) * 4 + b)]);
        end
        repeat (kind == 2 ? 2 : 1) send_bit(1'b0);
        pending = (kind == 0) ? 1 : 2;
        p_user = int'(user);
    endtask

    task automatic close_stream();
        repeat (10) send_bit(1'b0);
        send_bit(1'b1);
        apply_and_check();
        check("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        reset_dut();
        // three good frames, known content
        for (int c = 0; c < 8; c++) smp[c] = 24'($urandom);
        smp[0] = 24'h800001;
        repeat (3) send_frame(0, 4'hA);
        close_stream();
        check("ram_s0c0b0", ram[{3'd0, 3'd0, 5'd0}], 1);
        check("ram_s0c0b23", ram[{3'd0, 3'd0, 5'd23}], 1);
        check("ram_s0c0b1", ram[{3'd0, 3'd0, 5'd1}], 0);

        // good, broken separator, good
        reset_dut();
        rand_samples(); send_frame(0, 4'h3);
        rand_samples(); send_frame(1, 4'h5);
        rand_samples(); send_frame(0, 4'h9);
        close_stream();

        // slot index wraps
        reset_dut();
        for (int f = 0; f < 10; f++) begin
            rand_samples();
            send_frame(0, 4'($urandom));
        end
        close_stream();

        // lock, lose it on bad tails, regain it
        reset_dut();
        for (int f = 0; f < 6; f++) begin
            rand_samples();
            send_frame((f == 2 || f == 3) ? 2 : 0, 4'($urandom));
        end
        close_stream();

        // asynchronous reset mid-frame
        reset_dut();
        rand_samples(); send_frame(0, 4'h6);
        rand_samples(); send_frame(0, 4'hC);
        rand_samples(); send_frame(0, 4'h7, 20);
        reset_dut();
        repeat (20) begin
            send_bit(1'b1);
            repeat (4) send_bit(1'($urandom_range(0, 1)));
        end
        check("after_rst_resync", resync_req_o, 1);
        rand_samples(); send_frame(0, 4'h2);
        close_stream();

        // long zero run
        reset_dut();
        repeat (300) send_bit(1'b0);
        check("zeros_resync", resync_req_o, 1);
        check("zeros_wr_en", wr_en_o, 0);
        check("zeros_last_idx", last_good_frame_idx_o, 0);

        // random frame mix
        reset_dut();
        for (int f = 0; f < 8; f++) begin
            int r;
            r = $urandom_range(0, 5);
            rand_samples();
            send_frame(r < 4 ? 0 : r - 3, 4'($urandom));
        end
        close_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
